register_file_sb: RTL and testbench

Parametrised multi-port register file with an integrated scoreboard. It is the next generation of the team's 2-read/1-write register file, sitting between the decode stage (reservations, operand reads) and the writeback stage (results). Features:
- Synchronous reset.
- N registered read ports with write-first bypass.
- Two prioritised write ports.
- Per-register pending bits, so consumers can tell whether an operand is architecturally valid.

---
 rtl/register_file_sb_pkg.sv | 12 +
 rtl/register_file_sb_if.sv | 32 +++
 rtl/register_file_sb_scoreboard.sv | 46 ++++
 rtl/register_file_sb.sv | 76 +++++++
 tb/tb_register_file_sb.sv | 145 ++++++++++++++
 5 files changed

// File: rtl/register_file_sb_pkg.sv
// Shared constants and types for the scoreboarded register file.
// Optional build macro: REGFILE_ZERO_REG_EN (register 0 hardwired to zero).
package regfile_pkg;
  localparam int BIT_WIDTH        = 16;
  localparam int NUMBER_REGISTERS = 8;
  localparam int READ_PORTS       = 2;
  localparam int WRITE_PORTS      = 2;
  localparam int REGISTER_SELECT  = $clog2(NUMBER_REGISTERS);

  typedef logic [REGISTER_SELECT-1:0] reg_addr_t;
  typedef logic [BIT_WIDTH-1:0]       reg_data_t;
endpackage

// File: rtl/register_file_sb_if.sv
// Decode/writeback bus of the register file: writes, reservations and read ports.
interface register_file_sb_if
  import regfile_pkg::*;
#(
    parameter int Bit_Width        = BIT_WIDTH,
    parameter int Number_Registers = NUMBER_REGISTERS,
    parameter int Read_Ports       = READ_PORTS
);
    localparam int Register_Select = $clog2(Number_Registers);

    logic [WRITE_PORTS-1:0]                 Write_Enable;
    logic [WRITE_PORTS*Register_Select-1:0] Write_Destination;
    logic [WRITE_PORTS*Bit_Width-1:0]       Data_Destination;
    logic                                   Reserve_Enable;
    logic [Register_Select-1:0]             Reserve_Destination;
    logic [Read_Ports*Register_Select-1:0]  Source;
    logic [Read_Ports*Bit_Width-1:0]        Data;
    logic [Read_Ports-1:0]                  Data_Valid;
    logic                                   Reserve_Error;

    modport master (
        output Write_Enable, Write_Destination, Data_Destination,
        output Reserve_Enable, Reserve_Destination, Source,
        input  Data, Data_Valid, Reserve_Error
    );

    modport slave (
        input  Write_Enable, Write_Destination, Data_Destination,
        input  Reserve_Enable, Reserve_Destination, Source,
        output Data, Data_Valid, Reserve_Error
    );
endinterface

// File: rtl/register_file_sb_scoreboard.sv
// Pending-bit scoreboard: reset > reservation > write priority, plus Reserve_Error pulse.
// With REGFILE_ZERO_REG_EN, reservations of register 0 are ignored.
module regfile_scoreboard
  import regfile_pkg::*;
#(
    parameter int Number_Registers = NUMBER_REGISTERS,
    parameter int Register_Select  = $clog2(Number_Registers)
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic [WRITE_PORTS-1:0]                 write_enable,
    input  logic [WRITE_PORTS*Register_Select-1:0] write_destination,
    input  logic                                   reserve_enable,
    input  logic [Register_Select-1:0]             reserve_destination,
    output logic [Number_Registers-1:0]            pending_nxt,
    output logic                                   reserve_error
);
    logic [Number_Registers-1:0] pending_p0;
    logic                        reserve_ok;
    logic                        reserve_hit;

    always_comb begin
`ifdef REGFILE_ZERO_REG_EN
        reserve_ok = reserve_enable && (reserve_destination != '0);
`else
        reserve_ok = reserve_enable;
`endif
        // The error looks at the pre-edge bit, so a same-cycle write cannot mask it.
        reserve_hit = reserve_ok && pending_p0[reserve_destination];

        pending_nxt = pending_p0;
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (write_enable[w])
                pending_nxt[write_destination[w*Register_Select +: Register_Select]] = 1'b0;
        end
        if (reserve_ok)
            pending_nxt[reserve_destination] = 1'b1;
        if (rst)
            pending_nxt = '0;
    end

    always_ff @(posedge clk) begin
        pending_p0    <= pending_nxt;
        reserve_error <= rst ? 1'b0 : reserve_hit;
    end
endmodule

// File: rtl/register_file_sb.sv
// Multi-port register file with write-first bypass, two prioritised write ports and scoreboard.
// Optional build macro: REGFILE_ZERO_REG_EN (register 0 reads 0/valid, writes dropped).
module register_file_sb
  import regfile_pkg::*;
#(
    parameter int Bit_Width        = BIT_WIDTH,
    parameter int Number_Registers = NUMBER_REGISTERS,
    parameter int Register_Select  = $clog2(Number_Registers),
    parameter int Read_Ports       = READ_PORTS
) (
    input logic              clk,
    input logic              rst,
    register_file_sb_if.slave bus
);
    logic [Bit_Width-1:0]                   mem_p0  [Number_Registers];
    logic [Bit_Width-1:0]                   mem_nxt [Number_Registers];
    logic [Number_Registers-1:0]            pend_nxt;
    logic [Read_Ports-1:0][Register_Select-1:0] src_addr;
    logic [Read_Ports-1:0][Bit_Width-1:0]   rd_data_p1;
    logic [Read_Ports-1:0]                  rd_vld_p1;

    regfile_scoreboard #(
        .Number_Registers (Number_Registers),
        .Register_Select  (Register_Select)
    ) u_scoreboard (
        .clk                 (clk),
        .rst                 (rst),
        .write_enable        (bus.Write_Enable),
        .write_destination   (bus.Write_Destination),
        .reserve_enable      (bus.Reserve_Enable),
        .reserve_destination (bus.Reserve_Destination),
        .pending_nxt         (pend_nxt),
        .reserve_error       (bus.Reserve_Error)
    );

    // Post-edge storage image; port 1 is applied last so it wins on collisions.
    always_comb begin
        for (int i = 0; i < Number_Registers; i++)
            mem_nxt[i] = mem_p0[i];
        for (int w = 0; w < WRITE_PORTS; w++) begin
            if (bus.Write_Enable[w])
                mem_nxt[bus.Write_Destination[w*Register_Select +: Register_Select]] =
                    bus.Data_Destination[w*Bit_Width +: Bit_Width];
        end
        if (rst) begin
            for (int i = 0; i < Number_Registers; i++)
                mem_nxt[i] = '0;
        end
`ifdef REGFILE_ZERO_REG_EN
        mem_nxt[0] = '0;
`endif
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < Number_Registers; i++)
            mem_p0[i] <= mem_nxt[i];
    end

    assign src_addr = bus.Source;

    // Stage p1: read ports sample the post-edge image, which gives write-first bypass.
    always_ff @(posedge clk) begin
        for (int r = 0; r < Read_Ports; r++) begin
            if (rst) begin
                rd_data_p1[r] <= '0;
                rd_vld_p1[r]  <= 1'b1;
            end else begin
                rd_data_p1[r] <= mem_nxt[src_addr[r]];
                rd_vld_p1[r]  <= ~pend_nxt[src_addr[r]];
            end
        end
    end

    assign bus.Data       = rd_data_p1;
    assign bus.Data_Valid = rd_vld_p1;
endmodule

// File: tb/tb_register_file_sb.sv
// Randomised + directed scoreboard bench for register_file_sb against an array-based model.
module tb_register_file_sb;
  import regfile_pkg::*;

  localparam int BW = 16;
  localparam int NR = 8;
  localparam int RS = 3;
  localparam int RP = 2;
`ifdef REGFILE_ZERO_REG_EN
  localparam bit ZERO = 1'b1;
`else
  localparam bit ZERO = 1'b0;
`endif

  typedef struct packed {
    logic [RP*BW-1:0] data;
    logic [RP-1:0]    vld;
    logic             err;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  register_file_sb_if #(.Bit_Width(BW), .Number_Registers(NR), .Read_Ports(RP)) bus ();

  register_file_sb #(.Bit_Width(BW), .Number_Registers(NR), .Register_Select(RS), .Read_Ports(RP)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  exp_t exp_q[$];
  int   id_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  logic [BW-1:0] m_mem  [NR];
  bit            m_pend [NR];

  task automatic check(input string name, input int id, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s (step %0d): got %h, expected %h", name, id, act, req);
    end
  endtask

  // One clock of stimulus; the model advances to the state visible after the coming edge.
  task automatic step(input bit r, input logic [1:0] we,
                      input logic [RS-1:0] a0, input logic [RS-1:0] a1,
                      input logic [BW-1:0] d0, input logic [BW-1:0] d1,
                      input bit ren, input logic [RS-1:0] rd,
                      input logic [RS-1:0] s0, input logic [RS-1:0] s1, input int id);
    exp_t e;
    bit   err;
    rst                     = r;
    bus.Write_Enable        = we;
    bus.Write_Destination   = {a1, a0};
    bus.Data_Destination    = {d1, d0};
    bus.Reserve_Enable      = ren;
    bus.Reserve_Destination = rd;
    bus.Source              = {s1, s0};
    if (r) begin
      for (int i = 0; i < NR; i++) begin
        m_mem[i]  = '0;
        m_pend[i] = 1'b0;
      end
      e.data = '0;
      e.vld  = '1;
      e.err  = 1'b0;
    end else begin
      err = ren && m_pend[rd] && !(ZERO && rd == 0);
      if (we[0] && !(ZERO && a0 == 0)) begin m_mem[a0] = d0; m_pend[a0] = 1'b0; end
      if (we[1] && !(ZERO && a1 == 0)) begin m_mem[a1] = d1; m_pend[a1] = 1'b0; end
      if (ren && !(ZERO && rd == 0)) m_pend[rd] = 1'b1;
      e.data = {m_mem[s1], m_mem[s0]};
      e.vld  = {~m_pend[s1], ~m_pend[s0]};
      e.err  = err;
    end
    exp_q.push_back(e);
    id_q.push_back(id);
    @(negedge clk);
  endtask

  // Monitor: outputs are presented every cycle, compared one edge after issue.
  always @(posedge clk) begin
    exp_t e;
    int   id;
    #1;
    if (exp_q.size() > 0) begin
      e  = exp_q.pop_front();
      id = id_q.pop_front();
      for (int r = 0; r < RP; r++) begin
        check($sformatf("data%0d", r), id, 32'(bus.Data[r*BW +: BW]), 32'(e.data[r*BW +: BW]));
        check($sformatf("valid%0d", r), id, 32'(bus.Data_Valid[r]), 32'(e.vld[r]));
      end
      check("reserve_err", id, 32'(bus.Reserve_Error), 32'(e.err));
    end
  end

  initial begin
    // reset, then read R3 / R5
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, 3, 5, 1);
    step(1, 2'b00, 0, 0, 0, 0, 0, 0, 3, 5, 2);
    // write then read
    step(0, 2'b01, 1, 0, 16'h0015, 0, 0, 0, 3, 5, 3);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 1, 1, 4);
    // collision with bypass
    step(0, 2'b11, 2, 2, 16'hAAAA, 16'h5555, 0, 0, 2, 1, 5);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 2, 2, 6);
    // scoreboard sequence on R4
    step(0, 2'b00, 0, 0, 0, 0, 1, 4, 4, 3, 7);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 4, 8);
    step(0, 2'b01, 4, 0, 16'h1234, 0, 0, 0, 4, 4, 9);
    step(0, 2'b10, 0, 4, 0, 16'h4321, 1, 4, 4, 4, 10);
    step(0, 2'b00, 0, 0, 0, 0, 1, 4, 4, 4, 11);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 4, 4, 12);
    // reset mid-operation with pending R6
    step(0, 2'b01, 6, 0, 16'hBEEF, 0, 0, 0, 6, 6, 13);
    step(0, 2'b00, 0, 0, 0, 0, 1, 6, 6, 6, 14);
    step(1, 2'b01, 6, 0, 16'hCAFE, 0, 0, 0, 6, 6, 15);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 6, 6, 16);
    // register 0 behaviour
    step(0, 2'b01, 0, 0, 16'hFFFF, 0, 1, 0, 0, 0, 17);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 18);
    step(0, 2'b00, 0, 0, 0, 0, 1, 0, 0, 0, 19);
    step(0, 2'b00, 0, 0, 0, 0, 0, 0, 0, 0, 20);
    // randomised traffic
    for (int i = 0; i < 600; i++) begin
      step($urandom_range(0, 59) == 0, 2'($urandom),
           RS'($urandom), RS'($urandom), BW'($urandom), BW'($urandom),
           $urandom_range(0, 2) == 0, RS'($urandom),
           RS'($urandom), RS'($urandom), 100 + i);
    end
    repeat (3) @(negedge clk);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d entries left, expected 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
